// File: rtl/jstk_spi_reader.sv
// jstk_spi_reader
// Polls one PmodJSTK over SPI mode 0 at a fixed rate. It presents the most
// recent 10-bit X/Y deflection and the three button bits.
//
// Ports:
//   clk     in   system clock
//   clr_n   in   asynchronous active-low reset
//   led     in   [1:0] LED command bits, latched when a transaction starts
//   miso    in   SPI data from the joystick
//   ss      out  SPI slave select, active low
//   sclk    out  SPI clock, idles low
//   mosi    out  SPI data to the joystick
//   joy_x   out  [9:0] last X reading (512 = centre after reset)
//   joy_y   out  [9:0] last Y reading (512 = centre after reset)
//   btn     out  [2:0] last button bits
//   valid   out  one-cycle pulse on the cycle the outputs update
//   busy    out  high while a transaction is in progress
module jstk_spi_reader #(
  parameter int SCLK_HALF   = 100,
  parameter int SS_SETUP    = 1500,
  parameter int BYTE_GAP    = 1000,
  parameter int POLL_PERIOD = 1666667
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic [1:0] led,
  input  logic       miso,
  output logic       ss,
  output logic       sclk,
  output logic       mosi,
  output logic [9:0] joy_x,
  output logic [9:0] joy_y,
  output logic [2:0] btn,
  output logic       valid,
  output logic       busy
);

  // One shared phase timer covers the setup, half-bit and gap intervals.
  localparam int T_A   = (SS_SETUP > BYTE_GAP) ? SS_SETUP : BYTE_GAP;
  localparam int T_MAX = (T_A > SCLK_HALF) ? T_A : SCLK_HALF;
  localparam int CNT_W = $clog2(T_MAX + 1);
  localparam int PW    = $clog2(POLL_PERIOD + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_GAP,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [PW-1:0]    r_poll;
  logic             r_pending;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit;
  logic [2:0]       r_idx;
  logic [7:0]       r_tx;
  logic [7:0]       r_rx;
  logic             r_ss;
  logic             r_sclk;
  logic             r_mosi;

  // Received bytes 0..3. Bytes 1 and 3 only contribute their two low bits.
  logic [7:0]       r_x_lo;
  logic [1:0]       r_x_hi;
  logic [7:0]       r_y_lo;
  logic [1:0]       r_y_hi;

  logic [9:0]       r_joy_x;
  logic [9:0]       r_joy_y;
  logic [2:0]       r_btn;

  logic             w_poll_wrap;
  logic             w_start;
  logic             w_half_done;
  logic             w_rise;
  logic             w_bit_start;
  logic             w_bit_end;
  logic             w_byte_end;
  logic             w_timer_clr;

  assign w_poll_wrap = (r_poll == PW'(POLL_PERIOD - 1));
  assign w_start     = (r_state == S_IDLE) && r_pending;
  assign w_half_done = (r_cnt == CNT_W'(SCLK_HALF - 1));

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_rise       = 1'b0;
    w_bit_start  = 1'b0;
    w_bit_end    = 1'b0;
    w_byte_end   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_pending) w_state_next = S_SETUP;
      end
      S_SETUP: begin
        if (r_cnt == CNT_W'(SS_SETUP - 1)) begin
          w_state_next = S_SHIFT;
          w_bit_start  = 1'b1;
        end
      end
      S_SHIFT: begin
        if (w_half_done) begin
          if (!r_sclk) begin
            w_rise = 1'b1;
          end else begin
            w_bit_end = 1'b1;
            if (r_bit == 3'd7) begin
              w_byte_end   = 1'b1;
              w_state_next = (r_idx < 3'd4) ? S_GAP : S_DONE;
            end else begin
              w_bit_start = 1'b1;
            end
          end
        end
      end
      S_GAP: begin
        if (r_cnt == CNT_W'(BYTE_GAP - 1)) begin
          w_state_next = S_SHIFT;
          w_bit_start  = 1'b1;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
    // The timer restarts on every phase change, including each sclk half.
    w_timer_clr = (w_state_next != r_state) ||
                  ((r_state == S_SHIFT) && w_half_done);
  end

  // --------------------------------------------------------- poll timer
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_poll    <= '0;
      r_pending <= 1'b0;
    end else begin
      r_poll    <= w_poll_wrap ? '0 : r_poll + 1'b1;
      // A wrap on the same cycle as the clear keeps the request.
      r_pending <= w_poll_wrap | (r_pending & ~w_start);
    end
  end

  // ----------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_cnt   <= '0;
      r_bit   <= '0;
      r_idx   <= '0;
      r_tx    <= '0;
      r_rx    <= '0;
      r_ss    <= 1'b1;
      r_sclk  <= 1'b0;
      r_mosi  <= 1'b0;
      r_x_lo  <= '0;
      r_x_hi  <= '0;
      r_y_lo  <= '0;
      r_y_hi  <= '0;
      r_joy_x <= 10'd512;
      r_joy_y <= 10'd512;
      r_btn   <= '0;
    end else begin
      r_cnt <= (w_timer_clr || (r_state == S_IDLE)) ? '0 : r_cnt + 1'b1;

      if (w_start) begin
        r_ss  <= 1'b0;
        r_tx  <= {6'b100000, led};
        r_bit <= '0;
        r_idx <= '0;
      end else if (r_state == S_DONE) begin
        r_ss   <= 1'b1;
        r_mosi <= 1'b0;
      end

      // After eight shifts r_tx is all zeros, which gives the zero bytes 1..4.
      if (w_bit_start) begin
        r_mosi <= r_tx[7];
        r_tx   <= {r_tx[6:0], 1'b0};
      end

      if (w_rise) begin
        r_sclk <= 1'b1;
        r_rx   <= {r_rx[6:0], miso};
      end else if (w_bit_end) begin
        r_sclk <= 1'b0;
        r_bit  <= r_bit + 3'd1;
      end

      if (w_byte_end) begin
        r_idx <= r_idx + 3'd1;
        case (r_idx)
          3'd0:    r_x_lo <= r_rx;
          3'd1:    r_x_hi <= r_rx[1:0];
          3'd2:    r_y_lo <= r_rx;
          3'd3:    r_y_hi <= r_rx[1:0];
          default: begin
            // Last byte: publish on the same edge that enters DONE.
            r_joy_x <= {r_x_hi, r_x_lo};
            r_joy_y <= {r_y_hi, r_y_lo};
            r_btn   <= r_rx[2:0];
          end
        endcase
      end
    end
  end

  assign ss    = r_ss;
  assign sclk  = r_sclk;
  assign mosi  = r_mosi;
  assign joy_x = r_joy_x;
  assign joy_y = r_joy_y;
  assign btn   = r_btn;
  assign valid = (r_state == S_DONE);
  assign busy  = (r_state != S_IDLE);

endmodule

// File: tb/tb_jstk_spi_reader.sv
module tb_jstk_spi_reader;

  localparam int P_A = 20000;
  localparam int P_B = 5000;

  logic       clk = 1'b0;
  logic       clr_n;
  logic [1:0] led;
  logic       miso_a;
  logic       miso_b;

  logic       ss_a, sclk_a, mosi_a, valid_a, busy_a;
  logic [9:0] joy_x_a, joy_y_a;
  logic [2:0] btn_a;
  logic       ss_b, sclk_b, mosi_b, valid_b, busy_b;
  logic [9:0] joy_x_b, joy_y_b;
  logic [2:0] btn_b;

  always #5 clk = ~clk;

  jstk_spi_reader #(.POLL_PERIOD(P_A)) u_dut_a (
    .clk(clk), .clr_n(clr_n), .led(led), .miso(miso_a),
    .ss(ss_a), .sclk(sclk_a), .mosi(mosi_a),
    .joy_x(joy_x_a), .joy_y(joy_y_a), .btn(btn_a),
    .valid(valid_a), .busy(busy_a)
  );

  jstk_spi_reader #(.POLL_PERIOD(P_B)) u_dut_b (
    .clk(clk), .clr_n(clr_n), .led(led), .miso(miso_b),
    .ss(ss_b), .sclk(sclk_b), .mosi(mosi_b),
    .joy_x(joy_x_b), .joy_y(joy_y_b), .btn(btn_b),
    .valid(valid_b), .busy(busy_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // ------------------------------------------------ SPI slave + monitors
  logic [7:0] sbytes [0:4];
  logic [7:0] mbytes [0:4];
  logic [7:0] mcap = '0;
  int ncyc = 0;
  int bitn = 0;
  int rbits = 0;
  int mosi_bad = 0;
  int falls_a = 0, fall_a [0:3];
  int rise_a = 0, bits_at_rise_a = 0, first_rise_a = 0;
  int valid_cnt_a = 0, valid_cyc_a = 0;
  int falls_b = 0, fall_b [0:1];
  int rises_b = 0, rise_b1 = 0, valid_cnt_b = 0;
  logic prev_ss_a = 1'b1, prev_sclk_a = 1'b0, prev_mosi_a = 1'b0, prev_ss_b = 1'b1;

  always @(negedge clk) begin
    ncyc++;
    if (prev_ss_a && !ss_a) begin
      if (falls_a < 4) fall_a[falls_a] = ncyc;
      falls_a++;
      bitn   = 0;
      rbits  = 0;
      miso_a = sbytes[0][7];
    end
    if (!prev_sclk_a && sclk_a) begin
      if (rbits == 0) first_rise_a = ncyc;
      mcap = {mcap[6:0], mosi_a};
      rbits++;
      if ((rbits % 8) == 0 && rbits <= 40) mbytes[rbits/8 - 1] = mcap;
    end
    if (prev_sclk_a && !sclk_a) begin
      bitn++;
      if (bitn < 40) miso_a = sbytes[bitn/8][7 - (bitn % 8)];
    end
    if (prev_sclk_a && sclk_a && (mosi_a !== prev_mosi_a)) mosi_bad++;
    if (!prev_ss_a && ss_a) begin
      rise_a         = ncyc;
      bits_at_rise_a = rbits;
    end
    if (valid_a === 1'b1) begin
      valid_cnt_a++;
      valid_cyc_a = ncyc;
    end
    if (prev_ss_b && !ss_b) begin
      if (falls_b < 2) fall_b[falls_b] = ncyc;
      falls_b++;
    end
    if (!prev_ss_b && ss_b) begin
      if (rises_b == 0) rise_b1 = ncyc;
      rises_b++;
    end
    if (valid_b === 1'b1) valid_cnt_b++;
    prev_ss_a   = ss_a;
    prev_sclk_a = sclk_a;
    prev_mosi_a = mosi_a;
    prev_ss_b   = ss_b;
  end

  // ------------------------------------------------------------ stimulus
  int rel_cyc;
  int t;
  int d;

  initial begin
    clr_n  = 1'b0;
    led    = 2'b10;
    miso_a = 1'b0;
    miso_b = 1'b1;
    sbytes[0] = 8'h34; sbytes[1] = 8'h02; sbytes[2] = 8'hCD;
    sbytes[3] = 8'h01; sbytes[4] = 8'h05;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ss",    32'(ss_a),    32'd1);
    chk("rst_sclk",  32'(sclk_a),  32'd0);
    chk("rst_mosi",  32'(mosi_a),  32'd0);
    chk("rst_joy_x", 32'(joy_x_a), 32'd512);
    chk("rst_joy_y", 32'(joy_y_a), 32'd512);
    chk("rst_btn",   32'(btn_a),   32'd0);
    chk("rst_valid", 32'(valid_a), 32'd0);
    chk("rst_busy",  32'(busy_a),  32'd0);
    chk("rst_b_idle", 32'({ss_b, sclk_b, mosi_b, valid_b, busy_b}), 32'b10000);

    @(negedge clk);
    #2;
    clr_n   = 1'b1;
    rel_cyc = ncyc;

    // First transaction: full decode and MOSI content
    t = 0;
    while (falls_a < 1 && t < 25000) begin @(posedge clk); #1; t++; end
    chk("wait_start1", 32'(falls_a), 32'd1);
    d = fall_a[0] - rel_cyc;
    chk("start1_after_release", 32'(d >= P_A && d <= P_A + 1), 32'd1);
    repeat (10) @(posedge clk);
    #1;
    chk("busy_mid", 32'(busy_a), 32'd1);

    t = 0;
    while (valid_cnt_a < 1 && t < 15000) begin @(posedge clk); #1; t++; end
    chk("wait_valid1", 32'(valid_cnt_a), 32'd1);
    chk("valid_one_cycle", 32'(valid_a), 32'd0);
    chk("ss_high_after_done", 32'(ss_a), 32'd1);
    chk("joy_x_1", 32'(joy_x_a), 32'h234);
    chk("joy_y_1", 32'(joy_y_a), 32'h1CD);
    chk("btn_1",   32'(btn_a),   32'd5);
    chk("valid_latency", 32'(valid_cyc_a - fall_a[0]), 32'd13500);
    chk("first_sclk_rise", 32'(first_rise_a - fall_a[0]), 32'd1600);
    @(negedge clk);
    #1;
    chk("ss_rise_latency", 32'(rise_a - fall_a[0]), 32'd13501);
    chk("bits_per_window", 32'(bits_at_rise_a), 32'd40);
    chk("mosi_byte0", 32'(mbytes[0]), 32'h82);
    for (int i = 1; i < 5; i++) chk($sformatf("mosi_byte%0d", i), 32'(mbytes[i]), 32'h00);
    chk("mosi_stable_sclk_high", 32'(mosi_bad), 32'd0);

    // Overrun instance: back-to-back with a single ss-high cycle
    chk("ovr_falls", 32'(falls_b >= 2), 32'd1);
    chk("ovr_spacing", 32'(fall_b[1] - fall_b[0]), 32'd13502);
    chk("ovr_ss_gap", 32'(fall_b[1] - rise_b1), 32'd1);
    chk("ovr_joy", 32'({joy_x_b, joy_y_b, btn_b}), 32'({10'h3FF, 10'h3FF, 3'd7}));
    chk("ovr_valid_cnt", 32'(valid_cnt_b >= 1), 32'd1);

    // Second transaction: cadence, then reset during byte 2
    sbytes[0] = 8'hFF; sbytes[1] = 8'h03; sbytes[2] = 8'h00;
    sbytes[3] = 8'h00; sbytes[4] = 8'h02;
    t = 0;
    while (falls_a < 2 && t < 10000) begin @(posedge clk); #1; t++; end
    chk("wait_start2", 32'(falls_a), 32'd2);
    chk("poll_cadence", 32'(fall_a[1] - fall_a[0]), 32'd20000);
    t = 0;
    while (rbits < 20 && t < 10000) begin @(posedge clk); #1; t++; end
    chk("reach_byte2", 32'(rbits >= 20), 32'd1);
    #2;
    clr_n = 1'b0;
    #1;
    chk("midrst_ss", 32'(ss_a), 32'd1);
    chk("midrst_sclk", 32'(sclk_a), 32'd0);
    chk("midrst_joy", 32'({joy_x_a, joy_y_a, btn_a}), 32'({10'd512, 10'd512, 3'd0}));
    #3;
    clr_n   = 1'b1;
    rel_cyc = ncyc;

    t = 0;
    while (falls_a < 3 && t < 25000) begin @(posedge clk); #1; t++; end
    chk("wait_start3", 32'(falls_a), 32'd3);
    chk("no_valid_from_partial", 32'(valid_cnt_a), 32'd1);
    d = fall_a[2] - rel_cyc;
    chk("restart_after_reset", 32'(d >= P_A && d <= P_A + 1), 32'd1);
    t = 0;
    while (valid_cnt_a < 2 && t < 15000) begin @(posedge clk); #1; t++; end
    chk("wait_valid3", 32'(valid_cnt_a), 32'd2);
    chk("valid_latency3", 32'(valid_cyc_a - fall_a[2]), 32'd13500);
    chk("joy_x_3", 32'(joy_x_a), 32'h3FF);
    chk("joy_y_3", 32'(joy_y_a), 32'h000);
    chk("btn_3",   32'(btn_a),   32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
